// File: rtl/eggtimer_pkg.sv
// Shared widths, limits and mm:ss helpers for the egg timer blocks.
// Pure definitions; no clocked logic and no flow control.
package eggtimer_pkg;

    localparam int MIN_W           = 7;
    localparam int SEC_W           = 6;
    localparam int SEC_MAX         = 59;
    localparam int DEFAULT_MAX_MIN = 99;

    typedef struct packed {
        logic [MIN_W-1:0] mins;
        logic [SEC_W-1:0] secs;
    } mmss_t;

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] v,
                                                   input int              max_min);
        return (v > MIN_W'(max_min)) ? MIN_W'(max_min) : v;
    endfunction

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] v);
        return (v > SEC_W'(SEC_MAX)) ? SEC_W'(SEC_MAX) : v;
    endfunction

    function automatic logic mmss_is_zero(input mmss_t t);
        return (t.mins == '0) && (t.secs == '0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides i_clk by DIV into a one-cycle o_tick; counter holds while i_en=0.
// Tick is combinational on the last enabled count; i_clr restarts the phase.
module tick_prescaler #(
    parameter int DIV = 100_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(DIV - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss countdown: loads a clamped setting, steps down once per TICK_DIV enabled cycles.
// Count is registered (1 cycle after load/tick); o_timer_done is combinational from it.
module countdown_timer
    import eggtimer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = DEFAULT_MAX_MIN
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load_timer,
    input  logic             i_timer_enable,
    input  logic [MIN_W-1:0] i_load_minutes,
    input  logic [SEC_W-1:0] i_load_seconds,
    output logic [MIN_W-1:0] o_minutes,
    output logic [SEC_W-1:0] o_seconds,
    output logic             o_timer_done,
    output logic             o_done_pulse
);

    mmss_t r_count;
    mmss_t w_next;
    logic  r_done_pulse;
    logic  w_tick_raw;
    logic  w_tick;
    logic  w_arrive;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_en    (i_timer_enable),
        .i_clr   (i_load_timer),
        .o_tick  (w_tick_raw)
    );

    // A load in the same cycle swallows the tick.
    assign w_tick   = w_tick_raw && !i_load_timer;
    assign w_arrive = w_tick && (r_count.mins == '0) && (r_count.secs == SEC_W'(1));

    always_comb begin
        w_next = r_count;
        if (i_load_timer) begin
            w_next.mins = clamp_min(i_load_minutes, MAX_MIN);
            w_next.secs = clamp_sec(i_load_seconds);
        end else if (w_tick) begin
            if (r_count.secs != '0) begin
                w_next.secs = r_count.secs - SEC_W'(1);
            end else if (r_count.mins != '0) begin
                w_next.mins = r_count.mins - MIN_W'(1);
                w_next.secs = SEC_W'(SEC_MAX);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count      <= '0;
            r_done_pulse <= 1'b0;
        end else begin
            r_count      <= w_next;
            r_done_pulse <= w_arrive;
        end
    end

    assign o_minutes    = r_count.mins;
    assign o_seconds    = r_count.secs;
    assign o_timer_done = mmss_is_zero(r_count);
    assign o_done_pulse = r_done_pulse;

endmodule
